// File: rtl/alu_seq_pkg.sv
// Shared constants and the state encoding for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;
  // Op bit that selects the logic path (1) over the arithmetic path (0)
  localparam int OP_SEL  = 2;

endpackage

// File: rtl/alu_seq.sv
// Nibble-serial sequencer driving an external 4-bit ALU, LSB slice first.
// Optional abort input enabled by defining SEQ_ABORT_EN.
//
// state | meaning
// IDLE  | ready for a new operation
// RUN   | one slice per cycle through the external ALU
// DONE  | result registers valid, one-cycle done pulse
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
`ifdef SEQ_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   ready,
  input  logic [4*NIBBLES-1:0]   A_w,
  input  logic [4*NIBBLES-1:0]   B_w,
  input  logic [2:0]             Op,
  input  logic                   c_in,
  output logic [3:0]             alu_A,
  output logic [3:0]             alu_B,
  output logic [2:0]             alu_Op,
  output logic                   alu_cin,
  input  logic [3:0]             alu_R,
  input  logic                   alu_carry,
  output logic [4*NIBBLES-1:0]   R_w,
  output logic                   zero,
  output logic                   carry,
  output logic                   sign,
  output logic                   done
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry_reg;
  logic [W-1:0]    a_lat;
  logic [W-1:0]    b_lat;
  logic [2:0]      op_lat;
  logic            cin_lat;
  logic [W-1:0]    work;
  logic [W-1:0]    next_work;
  logic            last_slice;
  logic            abort_run;

`ifdef SEQ_ABORT_EN
  assign abort_run = abort;
`else
  assign abort_run = 1'b0;
`endif

  assign ready      = (state == IDLE);
  assign last_slice = (idx == IW'(NIBBLES - 1));

  always_comb begin
    alu_A   = '0;
    alu_B   = '0;
    alu_Op  = '0;
    alu_cin = 1'b0;
    if (state == RUN) begin
      alu_A  = a_lat[SLICE_W*idx +: SLICE_W];
      alu_B  = b_lat[SLICE_W*idx +: SLICE_W];
      alu_Op = op_lat;
      // logic ops see c_in only on slice 0; no carry chaining between slices
      if (op_lat[OP_SEL])
        alu_cin = (idx == '0) ? cin_lat : 1'b0;
      else
        alu_cin = carry_reg;
    end
  end

  always_comb begin
    next_work = work;
    next_work[SLICE_W*idx +: SLICE_W] = alu_R;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_lat     <= '0;
      b_lat     <= '0;
      op_lat    <= '0;
      cin_lat   <= 1'b0;
      work      <= '0;
      R_w       <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      sign      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_lat     <= A_w;
            b_lat     <= B_w;
            op_lat    <= Op;
            cin_lat   <= c_in;
            carry_reg <= c_in;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort_run) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            work      <= next_work;
            carry_reg <= alu_carry;
            if (last_slice) begin
              // results publish on the same edge that enters DONE
              R_w   <= next_work;
              zero  <= ~|next_work;
              sign  <= next_work[W-1];
              carry <= op_lat[OP_SEL] ? 1'b0 : alu_carry;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle nibble-serial sequencer wrapped around the existing 4-bit combinational ALU.
- Accepts a wide operation (4*NIBBLES bits) over a start/ready handshake.
- Issues one nibble per cycle to the ALU, LSB nibble first, chaining the ALU carry between slices.
- Collects the slice results and presents the wide result and flags with a one-cycle done pulse.
- The ALU is instantiated alongside it. This block both drives the ALU inputs and consumes its R/carry outputs.

Parameters:
- NIBBLES, 2: number of 4-bit slices; word width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- ready  output  1  high in IDLE only.
- A_w  input  W  operand A.
- B_w  input  W  operand B.
- Op  input  3  ALU operation; Op[2]=0 selects the arithmetic path, Op[2]=1 the logic path.
- c_in  input  1  carry-in for slice 0.
- alu_A  output  4  nibble of latched A for the current slice.
- alu_B  output  4  nibble of latched B for the current slice.
- alu_Op  output  3  latched Op.
- alu_cin  output  1  carry into the current slice.
- alu_R  input  4  ALU result for the current slice.
- alu_carry  input  1  ALU carry-out for the current slice.
- R_w  output  W  wide result.
- zero  output  1  high when R_w == 0.
- carry  output  1  final carry-out; 0 for logic ops.
- sign  output  1  R_w[W-1].
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-high), taken immediately, including mid-operation:
  - state=IDLE; slice index=0; carry register=0; working and output registers=0.
  - R_w=0, zero=1, carry=0, sign=0, done=0, ready=1.
  - alu_A/alu_B/alu_Op/alu_cin all 0.
- IDLE:
  - ready=1.
  - On start=1: latch A_w, B_w, Op, c_in; idx<=0; carry register<=c_in; go to RUN.
  - start with ready=0 is ignored, never queued.
- RUN (one slice per cycle):
  - alu_A = A_lat[4*idx+3:4*idx]; alu_B likewise; alu_Op = Op_lat.
  - alu_cin = carry register when Op_lat[2]=0; for Op_lat[2]=1, alu_cin = c_in_lat on slice 0 and 0 on later slices.
  - At the clock edge: working[4*idx+3:4*idx] <= alu_R; carry register <= alu_carry; idx <= idx+1.
  - When idx == NIBBLES-1, go to DONE.
- DONE (one cycle):
  - Output registers load from the working register at this state's entry edge.
  - done=1 for exactly one cycle; then return to IDLE.
  - carry = final slice carry if Op_lat[2]=0, else 0.
  - zero is computed over all W bits, never a per-slice AND.
  - sign = R_w MSB.
- Latency and throughput:
  - start sampled at edge t; outputs valid and done=1 in the cycle after edge t+NIBBLES.
  - A new start is accepted at the earliest in the cycle after done, giving throughput one op per NIBBLES+2 cycles.
- Output registers hold their value until the next completion. They never show partial results during RUN.
- Boundary cases:
  - idx wraps only through DONE→IDLE.
  - Input changes during RUN have no effect because operands are latched.
  - Operands of 0 with Op arithmetic and c_in=0 give zero=1.

Optional Feature:
- SEQ_ABORT_EN. When defined, adds an input port abort (1 bit).
  - abort=1 in RUN returns the FSM to IDLE at the next edge, with no done pulse.
  - Output registers keep the previous completed result.
  - abort in IDLE or DONE has no effect; DONE completes normally.
- When undefined, there is no abort port and every accepted start completes.

Decomposition:
- Package alu_seq_pkg holds:
  - state localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the slice width constant 4;
  - the Op[2] arithmetic/logic select bit index.
- No sub-module is needed. The nibble select mux and the wide zero reduction stay inline.
- The ALU remains a separate instance wired in the parent.

Test Plan:
- Bench stub ALU (R=A+B+cin, carry=cout), NIBBLES=2, Op=000, A=8'h3F, B=8'h01, c_in=0 → R_w=8'h40, carry=0, zero=0, sign=0, done exactly 3 cycles after the start edge.
- Stub, A=8'hFF, B=8'h01, c_in=0 → R_w=8'h00, carry=1, zero=1; carry chained into slice 1 (alu_cin=1 in the second RUN cycle).
- Stub, Op=100 (logic), A=8'hF0, B=8'h0F, c_in=1 → alu_cin=1 on slice 0 and 0 on slice 1; carry output=0.
- start held high for 10 cycles → exactly one op accepted per NIBBLES+2 cycles; ready low during RUN/DONE; R_w stable between done pulses.
- reset asserted in the second RUN cycle → immediately IDLE, R_w=0, zero=1, done never pulses; the next start completes normally.
- With SEQ_ABORT_EN, abort during RUN after a prior result of 8'h40 → no done, R_w stays 8'h40, ready=1 the next cycle.
